// File: rtl/alu_issue_stage.sv
// Registered issue/response wrapper around a combinational 64-bit ALU:
// an in-order command FIFO drives the ALU, and a valid/ready register captures results.
module alu_issue_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int SHW   = 5,
    parameter int TAGW  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [3:0]                 cmd_opcode,
    input  logic [WIDTH-1:0]           cmd_a,
    input  logic [WIDTH-1:0]           cmd_b,
    input  logic [SHW-1:0]             cmd_shift,
    input  logic [TAGW-1:0]            cmd_tag,
    output logic [3:0]                 alu_opcode,
    output logic [WIDTH-1:0]           alu_input1,
    output logic [WIDTH-1:0]           alu_input2,
    output logic [SHW-1:0]             alu_shiftValue,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carry,
    input  logic                       alu_zero,
    input  logic                       alu_overflow,
    input  logic                       alu_sign,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [3:0]                 rsp_flags,
    output logic [TAGW-1:0]            rsp_tag,
    output logic                       rsp_illegal,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [31:0]                ops_done
);

    localparam int AW = $clog2(DEPTH);

    logic [3:0]       mem_op    [DEPTH];
    logic [WIDTH-1:0] mem_a     [DEPTH];
    logic [WIDTH-1:0] mem_b     [DEPTH];
    logic [SHW-1:0]   mem_shift [DEPTH];
    logic [TAGW-1:0]  mem_tag   [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, head_valid, handoff, head_illegal;

    assign cmd_ready    = (count < (AW+1)'(DEPTH));
    assign push         = cmd_valid & cmd_ready;
    assign head_valid   = (count != '0);
    assign pop          = head_valid & (~rsp_valid | rsp_ready);
    assign handoff      = rsp_valid & rsp_ready;
    assign head_illegal = (mem_op[rd_ptr] > 4'd5);
    assign occupancy    = count;

    // ALU operands come only from storage, so there is no cmd_* to alu_* path.
    always_comb begin
        alu_opcode     = '0;
        alu_input1     = '0;
        alu_input2     = '0;
        alu_shiftValue = '0;
        if (head_valid) begin
            alu_opcode     = mem_op[rd_ptr];
            alu_input1     = mem_a[rd_ptr];
            alu_input2     = mem_b[rd_ptr];
            alu_shiftValue = mem_shift[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]    <= cmd_opcode;
            mem_a[wr_ptr]     <= cmd_a;
            mem_b[wr_ptr]     <= cmd_b;
            mem_shift[wr_ptr] <= cmd_shift;
            mem_tag[wr_ptr]   <= cmd_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_tag     <= '0;
            rsp_illegal <= 1'b0;
            ops_done    <= '0;
        end else begin
            if (pop) begin
                rsp_valid   <= 1'b1;
                rsp_tag     <= mem_tag[rd_ptr];
                rsp_illegal <= head_illegal;
                if (head_illegal) begin
                    rsp_result <= '0;
                    rsp_flags  <= '0;
                end else begin
                    rsp_result <= alu_result;
                    rsp_flags  <= {alu_carry, alu_zero, alu_overflow, alu_sign};
                end
            end else if (handoff) begin
                rsp_valid <= 1'b0;
            end
            if (handoff) ops_done <= ops_done + 32'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a behavioural ALU stub answers the DUT,
// accepted commands queue expected responses, and a monitor checks every handoff.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = '0;
    logic [63:0] cmd_a = '0, cmd_b = '0;
    logic [4:0]  cmd_shift = '0;
    logic [7:0]  cmd_tag = '0;
    logic [3:0]  alu_opcode;
    logic [63:0] alu_input1, alu_input2;
    logic [4:0]  alu_shiftValue;
    logic [63:0] alu_result;
    logic        alu_carry, alu_zero, alu_overflow, alu_sign;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [7:0]  rsp_tag;
    logic        rsp_illegal;
    logic [2:0]  occupancy;
    logic [31:0] ops_done;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    alu_issue_stage #(.WIDTH(64), .DEPTH(4), .SHW(5), .TAGW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_sign(alu_sign),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
        .occupancy(occupancy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    // Returns {result, carry, zero, overflow, sign}; illegal opcodes give all ones
    // so a DUT that fails to mask them is caught.
    function automatic logic [67:0] alu_model(input logic [3:0] op, input logic [63:0] a,
                                              input logic [63:0] b, input logic [4:0] sh);
        logic [64:0] wide;
        logic [63:0] r;
        logic        c, v;
        c = 1'b0; v = 1'b0; r = '0; wide = '0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[63:0]; c = wide[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            4'd1: begin
                r = a - b; c = (a < b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = $signed(a) >>> sh;
            4'd5: r = ~(a | b);
            default: return '1;
        endcase
        return {r, c, (r == 64'd0), v, r[63]};
    endfunction

    always_comb begin
        {alu_result, alu_carry, alu_zero, alu_overflow, alu_sign} =
            alu_model(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
    end

    typedef struct {
        logic [63:0] result;
        logic [3:0]  flags;
        logic [7:0]  tag;
        logic        illegal;
    } rsp_t;

    rsp_t exp_q[$];
    int unsigned hand_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Inputs change #1 after posedge, so negedge values are what the next edge sees.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            rsp_t e;
            logic [67:0] m;
            m = alu_model(cmd_opcode, cmd_a, cmd_b, cmd_shift);
            e.illegal = (cmd_opcode > 4'd5);
            e.result  = e.illegal ? 64'd0 : m[67:4];
            e.flags   = e.illegal ? 4'd0 : m[3:0];
            e.tag     = cmd_tag;
            exp_q.push_back(e);
        end
    end

    logic        prev_stall = 1'b0;
    logic [63:0] held_result;
    logic [7:0]  held_tag;
    logic [3:0]  held_flags;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            hand_cnt   = 0;
        end else begin
            if (prev_stall) begin
                check("stall_result", rsp_result, held_result);
                check("stall_tag", {56'd0, rsp_tag}, {56'd0, held_tag});
                check("stall_flags", {60'd0, rsp_flags}, {60'd0, held_flags});
            end
            check("ops_done", {32'd0, ops_done}, {32'd0, hand_cnt});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp_tag", {56'd0, rsp_tag}, 64'hDEAD);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    check("rsp_tag", {56'd0, rsp_tag}, {56'd0, e.tag});
                    check("rsp_result", rsp_result, e.result);
                    check("rsp_flags", {60'd0, rsp_flags}, {60'd0, e.flags});
                    check("rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e.illegal});
                end
                hand_cnt++;
            end
            prev_stall  = rsp_valid && !rsp_ready;
            held_result = rsp_result;
            held_tag    = rsp_tag;
            held_flags  = rsp_flags;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] sh, input logic [7:0] tag);
        logic acc;
        int unsigned budget;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        cmd_shift = sh; cmd_tag = tag;
        budget = 0;
        do begin
            @(negedge clk);
            acc = cmd_ready;
            tick();
            budget++;
        end while (!acc && budget < 50);
        if (!acc) check("send_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned budget;
        rsp_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || rsp_valid) && budget < 200) begin
            tick();
            budget++;
        end
        check("drain_done", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base;
        rst_n = 1'b0;
        #3;
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_occupancy", {61'd0, occupancy}, 64'd0);
        check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_alu_in1", alu_input1, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Latency: capture one edge after the push, ADD wraps to zero with carry.
        rsp_ready = 1'b1;
        send(4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd0, 8'h11);
        check("lat_not_yet", {63'd0, rsp_valid}, 64'd0);
        check("lat_alu_op_drive", alu_input1, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        check("lat_valid", {63'd0, rsp_valid}, 64'd1);
        check("add_result", rsp_result, 64'd0);
        check("add_flags", {60'd0, rsp_flags}, 64'b1100);
        check("add_tag", {56'd0, rsp_tag}, 64'h11);
        tick();
        check("add_ops_done", {32'd0, ops_done}, 64'd1);
        check("add_valid_drop", {63'd0, rsp_valid}, 64'd0);

        // Back-pressure: one held in the response register, four fill the FIFO.
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++)
            send(4'd3, 64'(i), 64'h100, 5'd0, 8'(8'h20 + i));
        cmd_valid = 1'b1; cmd_tag = 8'h25; cmd_opcode = 4'd2;
        tick();
        check("full_cmd_ready", {63'd0, cmd_ready}, 64'd0);
        check("full_occupancy", {61'd0, occupancy}, 64'd4);
        check("full_held_tag", {56'd0, rsp_tag}, 64'h20);
        cmd_valid = 1'b0;
        base = ops_done;
        rsp_ready = 1'b1;
        for (int unsigned i = 0; i < 5; i++) tick();
        check("burst_ops_done", {32'd0, ops_done}, 64'(base + 5));
        check("burst_empty", {63'd0, rsp_valid}, 64'd0);
        check("burst_occ", {61'd0, occupancy}, 64'd0);
        send(4'd2, 64'hF0F0, 64'hFF00, 5'd0, 8'h25);
        drain();

        // SRA, illegal opcode, then SUB.
        send(4'd4, 64'h8000_0000_0000_0000, 64'd0, 5'd4, 8'h30);
        tick();
        check("sra_result", rsp_result, 64'hF800_0000_0000_0000);
        check("sra_sign", {63'd0, rsp_flags[0]}, 64'd1);
        send(4'd9, 64'd5, 64'd3, 5'd0, 8'h31);
        tick();
        check("ill_flag", {63'd0, rsp_illegal}, 64'd1);
        check("ill_result", rsp_result, 64'd0);
        check("ill_flags", {60'd0, rsp_flags}, 64'd0);
        send(4'd1, 64'd5, 64'd3, 5'd0, 8'h32);
        tick();
        check("sub_result", rsp_result, 64'd2);
        check("sub_illegal", {63'd0, rsp_illegal}, 64'd0);
        drain();

        // Random traffic with random back-pressure.
        for (int unsigned i = 0; i < 1000; i++) begin
            cmd_valid  = ($urandom_range(0, 3) != 0);
            cmd_opcode = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15))
                                                      : 4'($urandom_range(0, 5));
            cmd_a      = {$urandom, $urandom};
            cmd_b      = ($urandom_range(0, 3) == 0) ? cmd_a : {$urandom, $urandom};
            cmd_shift  = 5'($urandom);
            cmd_tag    = 8'(i);
            rsp_ready  = ($urandom_range(0, 1) == 1);
            tick();
        end
        cmd_valid = 1'b0;
        drain();

        // Asynchronous reset with queued work and a pending response.
        rsp_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++)
            send(4'd0, 64'(i), 64'd7, 5'd0, 8'(8'h40 + i));
        check("pre_rst_occ", {61'd0, occupancy}, 64'd3);
        check("pre_rst_valid", {63'd0, rsp_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("arst_valid", {63'd0, rsp_valid}, 64'd0);
        check("arst_occ", {61'd0, occupancy}, 64'd0);
        check("arst_result", rsp_result, 64'd0);
        check("arst_tag", {56'd0, rsp_tag}, 64'd0);
        check("arst_ops_done", {32'd0, ops_done}, 64'd0);
        check("arst_alu_in2", alu_input2, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        rsp_ready = 1'b1;
        send(4'd5, 64'd0, 64'd0, 5'd0, 8'h55);
        tick();
        check("post_rst_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("post_rst_tag", {56'd0, rsp_tag}, 64'h55);
        drain();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
